// File: rtl/gpred_pht.sv
// gpred_pht: global-history branch predictor with a speculative GHR and a 2-bit-counter PHT.
// Indexing is gselect ({pc bits, GHR}) when HASH_MODE=0, or gshare (pc bits ^ GHR) when HASH_MODE=1.
// After reset an init sweep writes INIT_CTR to every entry while busy_o=1.
// Ports:
//   clk_i, reset_n_i                       clock, asynchronous active-low reset
//   lu_valid_i, lu_pc_i, lu_is_branch_i    fetch lookup request
//   lu_stall_i                             holds p_* and the GHR, and blocks acceptance
//   p_valid_o, p_dir_o, p_ctr_o, p_idx_o   registered prediction
//   p_hist_o                               GHR snapshot taken before this branch's shift
//   up_valid_i, up_idx_i, up_ctr_i         execute update of a resolved branch
//   up_dir_i, up_miss_i, up_hist_i         actual direction, mispredict flag, carried history
//   busy_o                                 init sweep in progress
//   stat_sel_i, stat_data_o                statistics read port
// Optional feature: define BPRED_STATS_EN to build four 32-bit event counters behind stat_data_o.
module gpred_pht #(
  parameter int          PHT_IDX_W = 11,
  parameter int          HIST_W    = 6,
  parameter int          HASH_MODE = 0,
  parameter logic [1:0]  INIT_CTR  = 2'b01
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 lu_valid_i,
  input  logic [31:0]          lu_pc_i,
  input  logic                 lu_is_branch_i,
  input  logic                 lu_stall_i,
  output logic                 p_valid_o,
  output logic                 p_dir_o,
  output logic [1:0]           p_ctr_o,
  output logic [PHT_IDX_W-1:0] p_idx_o,
  output logic [HIST_W-1:0]    p_hist_o,
  input  logic                 up_valid_i,
  input  logic [PHT_IDX_W-1:0] up_idx_i,
  input  logic [1:0]           up_ctr_i,
  input  logic                 up_dir_i,
  input  logic                 up_miss_i,
  input  logic [HIST_W-1:0]    up_hist_i,
  output logic                 busy_o,
  input  logic [1:0]           stat_sel_i,
  output logic [31:0]          stat_data_o
);
  typedef enum logic {INIT, READY} state_e;
  state_e                 state_q;
  logic [PHT_IDX_W-1:0]   sweep_q;
  logic [HIST_W-1:0]      ghr_q;
  logic                   p_valid_q, p_dir_q, p_br_q;
  logic [1:0]             p_ctr_q;
  logic [PHT_IDX_W-1:0]   p_idx_q;
  logic [HIST_W-1:0]      p_hist_q;
  logic [1:0]             pht_q [2**PHT_IDX_W];
  logic                   ready, acc, repair, shift, we;
  logic [PHT_IDX_W-1:0]   lu_idx, w_idx;
  logic [1:0]             up_sat, w_data, rd_ctr;
  logic                   unused_bits;
  if (HASH_MODE == 0) begin : g_gselect
    assign lu_idx = {lu_pc_i[PHT_IDX_W-HIST_W+1:2], ghr_q};
  end else begin : g_gshare
    assign lu_idx = lu_pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
  end
  // Only part of the PC, and none of the oldest carried history bit, feed the index.
  assign unused_bits = ^{lu_pc_i, up_hist_i[0], stat_sel_i};
  always_comb begin
    ready  = state_q == READY;
    acc    = ready & lu_valid_i & ~lu_stall_i;
    up_sat = up_dir_i ? ((up_ctr_i == 2'd3) ? 2'd3 : up_ctr_i + 2'd1)
                      : ((up_ctr_i == 2'd0) ? 2'd0 : up_ctr_i - 2'd1);
    we     = ~ready | up_valid_i;
    w_idx  = ready ? up_idx_i : sweep_q;
    w_data = ready ? up_sat : INIT_CTR;
    // Write-first: an update to the looked-up entry in the same cycle is seen by the lookup.
    rd_ctr = (ready & up_valid_i & (up_idx_i == lu_idx)) ? up_sat : pht_q[lu_idx];
    repair = ready & up_valid_i & up_miss_i;
    // Each presented branch shifts the GHR once, on the cycle it is consumed (not stalled).
    shift  = p_valid_q & p_br_q & ~lu_stall_i;
  end
  always_ff @(posedge clk_i) begin
    if (we) pht_q[w_idx] <= w_data;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= INIT;
      sweep_q   <= '0;
      ghr_q     <= '0;
      p_valid_q <= 1'b0;
      p_dir_q   <= 1'b0;
      p_br_q    <= 1'b0;
      p_ctr_q   <= '0;
      p_idx_q   <= '0;
      p_hist_q  <= '0;
    end else begin
      if (state_q == INIT) begin
        sweep_q <= sweep_q + 1'b1;
        if (&sweep_q) state_q <= READY;
      end
      ghr_q <= repair ? {up_dir_i, up_hist_i[HIST_W-1:1]} :
               shift  ? {p_dir_q, ghr_q[HIST_W-1:1]} : ghr_q;
      if (!lu_stall_i) begin
        p_valid_q <= acc;
        if (acc) begin
          p_dir_q  <= lu_is_branch_i & rd_ctr[1];
          p_br_q   <= lu_is_branch_i;
          p_ctr_q  <= rd_ctr;
          p_idx_q  <= lu_idx;
          p_hist_q <= ghr_q;
        end
      end
    end
  end
  assign p_valid_o = p_valid_q;
  assign p_dir_o   = p_dir_q;
  assign p_ctr_o   = p_ctr_q;
  assign p_idx_o   = p_idx_q;
  assign p_hist_o  = p_hist_q;
  assign busy_o    = state_q == INIT;
`ifdef BPRED_STATS_EN
  logic [31:0] st_q [4];
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 4; i++) st_q[i] <= '0;
    end else begin
      st_q[0] <= st_q[0] + 32'(acc);
      st_q[1] <= st_q[1] + 32'(acc & lu_is_branch_i);
      st_q[2] <= st_q[2] + 32'(ready & up_valid_i);
      st_q[3] <= st_q[3] + 32'(repair);
    end
  end
  assign stat_data_o = st_q[stat_sel_i];
`else
  assign stat_data_o = '0;
`endif
endmodule
